// File: rtl/bc_framer.sv
// Byte framer: packs a 16-bit word stream into frames of
// SYNC, LEN, payload (MSB first) and an XOR checksum.
module bc_framer #(
    parameter int unsigned WORDS_PER_FRAME = 4,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
    parameter int unsigned STALL_TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        word_in_rdy,
    input  logic        word_in_valid,
    input  logic [15:0] word_in_data,
    input  logic        byte_out_rdy,
    output logic        byte_out_valid,
    output logic [7:0]  byte_out_data,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    localparam int unsigned WCNT_W  = 7;
    localparam int unsigned STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [WCNT_W-1:0] WPF      = WCNT_W'(WORDS_PER_FRAME);
    localparam logic [7:0]        LEN_BYTE = 8'(2 * WORDS_PER_FRAME);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_HI    = 3'd4;
    localparam logic [2:0] ST_LO    = 3'd5;
    localparam logic [2:0] ST_CSUM  = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [15:0]        word_q, word_d;
    logic [7:0]         csum_q, csum_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               byte_out_valid_q, byte_out_valid_d;
    logic [7:0]         byte_out_data_q, byte_out_data_d;
    logic               busy_q, busy_d;

    logic stall_hit;
    logic byte_xfer;
    logic word_xfer;

    // Pad cycle: the stall counter has reached the limit, so no word is taken.
    assign stall_hit   = (STALL_TIMEOUT != 0) && (state_q == ST_FETCH) &&
                         (stall_q == STALL_W'(STALL_TIMEOUT));
    assign word_in_rdy = (state_q == ST_FETCH) && !stall_hit;
    assign byte_xfer   = byte_out_valid_q && byte_out_rdy;
    assign word_xfer   = word_in_valid && word_in_rdy;

    always_comb begin
        state_d          = state_q;
        word_d           = word_q;
        csum_d           = csum_q;
        wcnt_d           = wcnt_q;
        stall_d          = stall_q;
        frame_cnt_d      = frame_cnt_q;
        timeout_err_d    = 1'b0;
        byte_out_valid_d = 1'b0;
        byte_out_data_d  = byte_out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (word_in_valid) begin
                    state_d = ST_SYNC;
                    csum_d  = 8'h00;
                    wcnt_d  = '0;
                end
            end
            ST_SYNC: begin
                if (byte_xfer) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_xfer) begin
                    csum_d  = csum_q ^ LEN_BYTE;
                    stall_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (word_xfer) begin
                    word_d  = word_in_data;
                    stall_d = '0;
                    state_d = ST_HI;
                end else if (stall_hit) begin
                    word_d        = 16'h0000;
                    stall_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_HI;
                end else if (STALL_TIMEOUT != 0) begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            ST_HI: begin
                if (byte_xfer) begin
                    csum_d  = csum_q ^ byte_out_data_q;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (byte_xfer) begin
                    csum_d  = csum_q ^ byte_out_data_q;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    stall_d = '0;
                    state_d = (wcnt_d == WPF) ? ST_CSUM : ST_FETCH;
                end
            end
            ST_CSUM: begin
                if (byte_xfer) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Present the byte belonging to the state being entered (or held).
        case (state_d)
            ST_SYNC: begin byte_out_valid_d = 1'b1; byte_out_data_d = SYNC_BYTE;    end
            ST_LEN:  begin byte_out_valid_d = 1'b1; byte_out_data_d = LEN_BYTE;     end
            ST_HI:   begin byte_out_valid_d = 1'b1; byte_out_data_d = word_d[15:8]; end
            ST_LO:   begin byte_out_valid_d = 1'b1; byte_out_data_d = word_d[7:0];  end
            ST_CSUM: begin byte_out_valid_d = 1'b1; byte_out_data_d = csum_d;       end
            default: byte_out_valid_d = 1'b0;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            word_q           <= 16'h0000;
            csum_q           <= 8'h00;
            wcnt_q           <= '0;
            stall_q          <= '0;
            frame_cnt_q      <= 16'h0000;
            timeout_err_q    <= 1'b0;
            byte_out_valid_q <= 1'b0;
            byte_out_data_q  <= 8'h00;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_q           <= word_d;
            csum_q           <= csum_d;
            wcnt_q           <= wcnt_d;
            stall_q          <= stall_d;
            frame_cnt_q      <= frame_cnt_d;
            timeout_err_q    <= timeout_err_d;
            byte_out_valid_q <= byte_out_valid_d;
            byte_out_data_q  <= byte_out_data_d;
            busy_q           <= busy_d;
        end
    end

    assign byte_out_valid = byte_out_valid_q;
    assign byte_out_data  = byte_out_data_q;
    assign busy           = busy_q;
    assign frame_cnt      = frame_cnt_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_bc_framer.sv
// Directed bench for bc_framer: dut0 never pads, dut1 pads after 8 stalled cycles.
module tb_bc_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        bor;
    logic [1:0]  wv, wrdy, bov, busy, terr;
    logic [15:0] wd  [2];
    logic [7:0]  bod [2];
    logic [15:0] fc  [2];

    bc_framer #(.WORDS_PER_FRAME(4), .SYNC_BYTE(8'hA5), .STALL_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .word_in_rdy(wrdy[0]), .word_in_valid(wv[0]),
        .word_in_data(wd[0]), .byte_out_rdy(bor), .byte_out_valid(bov[0]),
        .byte_out_data(bod[0]), .busy(busy[0]), .frame_cnt(fc[0]), .timeout_err(terr[0]));

    bc_framer #(.WORDS_PER_FRAME(4), .SYNC_BYTE(8'hA5), .STALL_TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .word_in_rdy(wrdy[1]), .word_in_valid(wv[1]),
        .word_in_data(wd[1]), .byte_out_rdy(bor), .byte_out_valid(bov[1]),
        .byte_out_data(bod[1]), .busy(busy[1]), .frame_cnt(fc[1]), .timeout_err(terr[1]));

    // Packed arrays: element 0 is the rightmost entry of each literal.
    typedef struct {
        int               inst;
        int               nw;
        logic [3:0][15:0] w;
        bit               toggle;
        int               hold_at;
        int               hold_len;
        logic [10:0][7:0] exp;
        int               exp_terr;
        int               exp_run;
    } vec_t;

    vec_t vt [4];

    logic [15:0] src [2][16];
    logic [7:0]  got [2][32];
    int          nsrc [2], sidx [2], ngot [2], nterr [2], run [2], max_run [2];
    int          hold_at [2], hold_left [2];
    bit          prev_stall [2];
    logic [7:0]  prev_byte [2];
    bit          toggle;
    int          vecs = 0;
    int          errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, sample well before the next.
    task automatic step();
        @(posedge clk);
        #1;
        bor = toggle ? ~bor : 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (hold_left[k] > 0 && sidx[k] == hold_at[k]) begin
                wv[k] = 1'b0;
                hold_left[k]--;
            end else begin
                wv[k] = (sidx[k] < nsrc[k]);
            end
            if (wv[k]) wd[k] = src[k][sidx[k]];
            else       wd[k] = 16'h0000;
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            if (prev_stall[k]) check("stall_hold", {23'd0, bov[k], bod[k]}, {23'd0, 1'b1, prev_byte[k]});
            prev_stall[k] = bov[k] && !bor;
            prev_byte[k]  = bod[k];
            if (bov[k] && bor && ngot[k] < 32) begin
                got[k][ngot[k]] = bod[k];
                ngot[k]++;
            end
            if (wv[k] && wrdy[k]) sidx[k]++;
            if (terr[k]) nterr[k]++;
            if (busy[k] && !bov[k]) run[k]++;
            else                    run[k] = 0;
            if (run[k] > max_run[k]) max_run[k] = run[k];
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < 2; k++) begin
            nsrc[k] = 0; sidx[k] = 0; ngot[k] = 0; nterr[k] = 0;
            run[k] = 0; max_run[k] = 0; hold_at[k] = -1; hold_left[k] = 0;
            prev_stall[k] = 1'b0;
        end
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, "_valid"}, {31'd0, bov[k]}, 32'd0);
        check({tag, "_data"},  {24'd0, bod[k]}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy[k]}, 32'd0);
        check({tag, "_rdy"},   {31'd0, wrdy[k]}, 32'd0);
        check({tag, "_terr"},  {31'd0, terr[k]}, 32'd0);
        check({tag, "_fcnt"},  {16'd0, fc[k]}, 32'd0);
    endtask

    task automatic do_reset();
        toggle = 1'b0;
        clear_src();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until n bytes are out and the framer has returned to IDLE.
    task automatic run_frame(input int k, input int n);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            done = (ngot[k] >= n) && !busy[k];
        end
        check("frame_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [10:0][7:0] e2;
        bit hit;

        rst = 1'b1; bor = 1'b1; wv = 2'b00; wd[0] = 16'h0; wd[1] = 16'h0;
        toggle = 1'b0;
        clear_src();

        vt[0] = '{0, 4, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 1'b0, -1, 0,
                  {8'h08, 8'h0D, 8'h00, 8'h0C, 8'h00, 8'h0B, 8'h00, 8'h0A, 8'h00, 8'h08, 8'hA5}, 0, 1};
        vt[1] = '{0, 4, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 1'b1, -1, 0,
                  {8'h08, 8'h0D, 8'h00, 8'h0C, 8'h00, 8'h0B, 8'h00, 8'h0A, 8'h00, 8'h08, 8'hA5}, 0, 1};
        // 20 held cycles: HI, LO, then 18 idle FETCH cycles plus the cycle that takes word 3.
        vt[2] = '{0, 4, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 1'b0, 2, 20,
                  {8'h08, 8'h0D, 8'h00, 8'h0C, 8'h00, 8'h0B, 8'h00, 8'h0A, 8'h00, 8'h08, 8'hA5}, 0, 19};
        // Checksum 08^12^34^56^78^00^00^00^00 = 00; each pad waits 9 FETCH cycles.
        vt[3] = '{1, 2, {16'h0000, 16'h0000, 16'h5678, 16'h1234}, 1'b0, -1, 0,
                  {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'hA5}, 2, 9};

        for (int v = 0; v < 4; v++) begin
            int k;
            k = vt[v].inst;
            do_reset();
            check_reset(k, "reset");
            toggle = vt[v].toggle;
            for (int i = 0; i < vt[v].nw; i++) src[k][i] = vt[v].w[i];
            nsrc[k]      = vt[v].nw;
            hold_at[k]   = vt[v].hold_at;
            hold_left[k] = vt[v].hold_len;
            run_frame(k, 11);
            check("byte_count", ngot[k], 32'd11);
            for (int i = 0; i < 11; i++) check("frame_byte", {24'd0, got[k][i]}, {24'd0, vt[v].exp[i]});
            check("timeout_pulses", nterr[k], vt[v].exp_terr);
            check("longest_bubble", max_run[k], vt[v].exp_run);
            check("words_used", sidx[k], nsrc[k]);
            check("frame_cnt", {16'd0, fc[k]}, 32'd1);
        end

        // Reset while HI of word 3 of a second frame is on the link.
        do_reset();
        for (int i = 0; i < 8; i++) src[0][i] = 16'h0010 + 16'(i);
        nsrc[0] = 8;
        run_frame(0, 11);
        check("pre_reset_fcnt", {16'd0, fc[0]}, 32'd1);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            step();
            hit = (sidx[0] == 7) && bov[0];
        end
        check("reach_hi_word3", {31'd0, hit}, 32'd1);
        check("hi_word3_byte", {24'd0, bod[0]}, 32'h00);
        rst = 1'b1;
        step();
        check_reset(0, "midframe_reset");
        rst = 1'b0;
        clear_src();
        for (int i = 0; i < 4; i++) src[0][i] = vt[0].w[i];
        nsrc[0] = 4;
        run_frame(0, 11);
        for (int i = 0; i < 11; i++) check("resync_byte", {24'd0, got[0][i]}, {24'd0, vt[0].exp[i]});
        check("resync_fcnt", {16'd0, fc[0]}, 32'd1);

        // frame_cnt wrap, then back-to-back frames with an always-valid source.
        force dut0.frame_cnt_q = 16'hFFFF;
        step();
        release dut0.frame_cnt_q;
        step();
        check("forced_fcnt", {16'd0, fc[0]}, 32'h0000FFFF);
        clear_src();
        for (int i = 0; i < 4; i++) src[0][i] = vt[0].w[i];
        src[0][4] = 16'hFF00; src[0][5] = 16'h8001; src[0][6] = 16'h0102; src[0][7] = 16'hA55A;
        nsrc[0] = 8;
        run_frame(0, 11);
        check("wrap_fcnt", {16'd0, fc[0]}, 32'd0);
        check("idle_gap_busy", {31'd0, busy[0]}, 32'd0);
        run_frame(0, 22);
        check("second_fcnt", {16'd0, fc[0]}, 32'd1);
        e2 = {8'h8A, 8'h5A, 8'hA5, 8'h02, 8'h01, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h08, 8'hA5};
        for (int i = 0; i < 11; i++) check("second_byte", {24'd0, got[0][11 + i]}, {24'd0, e2[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
